// File: rtl/legv8_enc_pkg.sv
// Shared LEGv8 encoding constants: format codes, field placement and
// immediate range-check helpers. The decoder extracts from these positions.
package legv8_enc_pkg;

  typedef enum logic [1:0] {
    FMT_R  = 2'd0,
    FMT_D  = 2'd1,
    FMT_B  = 2'd2,
    FMT_CB = 2'd3
  } fmt_e;

  // Opcode placement per format
  localparam int OPC_RD_LSB = 21;
  localparam int OPC_RD_W   = 11;
  localparam int OPC_B_LSB  = 26;
  localparam int OPC_B_W    = 6;
  localparam int OPC_CB_LSB = 24;
  localparam int OPC_CB_W   = 8;

  // Immediate placement per format
  localparam int IMM26_LSB = 0;
  localparam int IMM26_W   = 26;
  localparam int IMM19_LSB = 5;
  localparam int IMM19_W   = 19;
  localparam int IMM9_LSB  = 12;
  localparam int IMM9_W    = 9;
  localparam int SHAMT_LSB = 10;
  localparam int SHAMT_W   = 6;

  // Register field placement
  localparam int RM_LSB = 16;
  localparam int RN_LSB = 5;
  localparam int RT_LSB = 0;
  localparam int REG_W  = 5;

  // True when v is representable as a w-bit two's complement value,
  // i.e. bits [63:w-1] are all copies of the sign bit.
  function automatic logic fits_signed(input logic [63:0] v, input int unsigned w);
    logic [63:0] upper;
    upper = 64'($signed(v) >>> (w - 1));
    return (upper == '0) || (upper == '1);
  endfunction

  // True when v is representable as a w-bit unsigned value.
  function automatic logic fits_unsigned(input logic [63:0] v, input int unsigned w);
    return (v >> w) == '0;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO; the head entry is a register so the read side is
// glitch-free and stable while the consumer stalls.
module enc_fifo2 #(
  parameter int WIDTH = 42
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);

  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [WIDTH-1:0] entry_q [2];
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow so the pointers can never desync
  assign do_push = push && (count_reg != 2'd2);
  assign do_pop  = pop && (count_reg != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;

      // Storage slot gi: captures wr_data when the write pointer selects it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= wr_data;
        end
      end

      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; simultaneous push+pop keeps count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = entry_q[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction encoder: packs format/opcode/immediate/register fields
// into 32-bit words, range-checks the immediate, and streams the words with
// sequential addresses into a 2-entry output FIFO.
module legv8_instr_encoder
  import legv8_enc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [10:0]       in_opcode,
  input  logic [63:0]       in_imm,
  input  logic [4:0]        in_rm,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rt,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic              err_sticky,
  input  logic              err_clr
);

  localparam int ENTRY_W = 32 + ADDR_W;

  fmt_e               fmt;
  logic [31:0]        word_next;
  logic               in_range;
  logic               accept;
  logic               push;
  logic               reject;
  logic               pop;
  logic [1:0]         fifo_count;
  logic [ENTRY_W-1:0] head_data;
  logic [ADDR_W-1:0]  addr_reg;
  logic               err_reg;
  logic               err_sticky_reg;

  assign fmt = fmt_e'(in_fmt);

  // Field packing and immediate range check for the presented command
  always_comb begin
    word_next = '0;
    in_range  = 1'b0;
    case (fmt)
      FMT_B: begin
        word_next[OPC_B_LSB +: OPC_B_W] = in_opcode[OPC_B_W-1:0];
        word_next[IMM26_LSB +: IMM26_W] = in_imm[IMM26_W-1:0];
        in_range = fits_signed(in_imm, IMM26_W);
      end
      FMT_CB: begin
        word_next[OPC_CB_LSB +: OPC_CB_W] = in_opcode[OPC_CB_W-1:0];
        word_next[IMM19_LSB +: IMM19_W]   = in_imm[IMM19_W-1:0];
        word_next[RT_LSB +: REG_W]        = in_rt;
        in_range = fits_signed(in_imm, IMM19_W);
      end
      FMT_D: begin
        word_next[OPC_RD_LSB +: OPC_RD_W] = in_opcode;
        word_next[IMM9_LSB +: IMM9_W]     = in_imm[IMM9_W-1:0];
        word_next[RN_LSB +: REG_W]        = in_rn;
        word_next[RT_LSB +: REG_W]        = in_rt;
        in_range = fits_signed(in_imm, IMM9_W);
      end
      default: begin
        word_next[OPC_RD_LSB +: OPC_RD_W] = in_opcode;
        word_next[RM_LSB +: REG_W]        = in_rm;
        word_next[SHAMT_LSB +: SHAMT_W]   = in_imm[SHAMT_W-1:0];
        word_next[RN_LSB +: REG_W]        = in_rn;
        word_next[RT_LSB +: REG_W]        = in_rt;
        in_range = fits_unsigned(in_imm, SHAMT_W);
      end
    endcase
  end

  // Ready only depends on current occupancy: no pass-through when full
  assign in_ready = (fifo_count != 2'd2);
  assign accept   = in_valid && in_ready;
  assign push     = accept && in_range;
  assign reject   = accept && !in_range;
  assign pop      = out_valid && out_ready;

  enc_fifo2 #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data ({word_next, addr_reg}),
    .pop     (pop),
    .rd_data (head_data),
    .count   (fifo_count)
  );

  assign out_valid = (fifo_count != 2'd0);
  assign out_word  = head_data[ENTRY_W-1:ADDR_W];
  assign out_addr  = head_data[ADDR_W-1:0];

  // Word address counter: an explicit load overrides the post-push increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else if (addr_load) begin
      addr_reg <= addr_value;
    end else if (push) begin
      addr_reg <= addr_reg + ADDR_W'(1);
    end
  end

  // Error pulse and sticky flag; a new rejection beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg        <= 1'b0;
      err_sticky_reg <= 1'b0;
    end else begin
      err_reg <= reject;
      if (reject) begin
        err_sticky_reg <= 1'b1;
      end else if (err_clr) begin
        err_sticky_reg <= 1'b0;
      end
    end
  end

  assign err        = err_reg;
  assign err_sticky = err_sticky_reg;

endmodule
